// File: rtl/bank_ctrl_write.sv
// Bank timing controller: sequences precharge, write drive, sample and sense-amp enables.
// Optional BANK_CTRL_PRE_HOLD_EN enforces a minimum PRE dwell of PRE_CYCLES after each operation.
module bank_ctrl_write #(
    parameter int unsigned WR_CYCLES  = 1,
    parameter int unsigned S1_CYCLES  = 1,
    parameter int unsigned S2_CYCLES  = 1,
    parameter int unsigned PRE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic w_en,
    input  logic r_en,
    output logic preb,
    output logic w_drv,
    output logic sampleb,
    output logic sa_en
);

    typedef enum logic [1:0] {
        StPre    = 2'd0,
        StWrite  = 2'd1,
        StSense1 = 2'd2,
        StSense2 = 2'd3
    } state_e;

    if (WR_CYCLES < 1 || WR_CYCLES > 15 || S1_CYCLES < 1 || S1_CYCLES > 15 ||
        S2_CYCLES < 1 || S2_CYCLES > 15 || PRE_CYCLES < 1 || PRE_CYCLES > 15) begin : g_param_check
        $error("bank_ctrl_write: cycle parameters must be in 1..15");
    end

    localparam logic [3:0] WrLoad = 4'(WR_CYCLES - 1);
    localparam logic [3:0] S1Load = 4'(S1_CYCLES - 1);
    localparam logic [3:0] S2Load = 4'(S2_CYCLES - 1);
`ifdef BANK_CTRL_PRE_HOLD_EN
    // Nonzero count in PRE blocks request acceptance until it drains.
    localparam logic [3:0] PreLoad = 4'(PRE_CYCLES);
`else
    localparam logic [3:0] PreLoad = 4'd0;
`endif

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       preb_d, w_drv_d, sampleb_d, sa_en_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StPre: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (w_en) begin
                    state_d = StWrite;
                    cnt_d   = WrLoad;
                end else if (r_en) begin
                    state_d = StSense1;
                    cnt_d   = S1Load;
                end
            end
            StWrite: begin
                if (cnt_q == 4'd0) begin
                    state_d = StPre;
                    cnt_d   = PreLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSense1: begin
                if (cnt_q == 4'd0) begin
                    state_d = StSense2;
                    cnt_d   = S2Load;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSense2: begin
                if (cnt_q == 4'd0) begin
                    state_d = StPre;
                    cnt_d   = PreLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StPre;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs decoded from the next state and registered, so they never glitch.
    always_comb begin
        preb_d    = 1'b0;
        w_drv_d   = 1'b0;
        sampleb_d = 1'b1;
        sa_en_d   = 1'b0;
        unique case (state_d)
            StPre: begin
                preb_d = 1'b0;
            end
            StWrite: begin
                preb_d  = 1'b1;
                w_drv_d = 1'b1;
            end
            StSense1: begin
                preb_d    = 1'b1;
                sampleb_d = 1'b0;
            end
            StSense2: begin
                preb_d  = 1'b1;
                sa_en_d = 1'b1;
            end
            default: begin
                preb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPre;
            cnt_q   <= 4'd0;
            preb    <= 1'b0;
            w_drv   <= 1'b0;
            sampleb <= 1'b1;
            sa_en   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            preb    <= preb_d;
            w_drv   <= w_drv_d;
            sampleb <= sampleb_d;
            sa_en   <= sa_en_d;
        end
    end

endmodule

// File: tb/tb_bank_ctrl_write.sv
// Directed bench for bank_ctrl_write with default parameters (hold feature disabled).
module tb_bank_ctrl_write;

    logic clk = 1'b0;
    logic rst;
    logic w_en;
    logic r_en;
    logic preb, w_drv, sampleb, sa_en;

    int errors = 0;
    int checks = 0;

    // Output vectors as {preb, w_drv, sampleb, sa_en}
    localparam logic [3:0] VPre    = 4'b0010;
    localparam logic [3:0] VWrite  = 4'b1110;
    localparam logic [3:0] VSense1 = 4'b1000;
    localparam logic [3:0] VSense2 = 4'b1011;

    bank_ctrl_write dut (
        .clk     (clk),
        .rst     (rst),
        .w_en    (w_en),
        .r_en    (r_en),
        .preb    (preb),
        .w_drv   (w_drv),
        .sampleb (sampleb),
        .sa_en   (sa_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] expected);
        logic [3:0] observed;
        observed = {preb, w_drv, sampleb, sa_en};
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        rst  = 1'b1;
        w_en = 1'b0;
        r_en = 1'b0;
        #1;
        check("reset_async", VPre);
        repeat (2) step();
        check("reset_held", VPre);
        rst = 1'b0;
        step();
        check("idle_1", VPre);
        step();
        check("idle_2", VPre);

        // Single write
        w_en = 1'b1;
        step();
        check("write_active", VWrite);
        w_en = 1'b0;
        step();
        check("write_done", VPre);
        step();
        check("write_idle", VPre);

        // Single read
        r_en = 1'b1;
        step();
        check("read_sense1", VSense1);
        r_en = 1'b0;
        step();
        check("read_sense2", VSense2);
        step();
        check("read_done", VPre);
        step();
        check("read_idle", VPre);

        // Write, one PRE cycle, read
        w_en = 1'b1;
        step();
        check("b2b_write", VWrite);
        w_en = 1'b0;
        step();
        check("b2b_pre", VPre);
        r_en = 1'b1;
        step();
        check("b2b_sense1", VSense1);
        step();  // r_en still high but ignored outside PRE
        check("b2b_sense2", VSense2);
        r_en = 1'b0;
        step();
        check("b2b_done", VPre);

        // Simultaneous requests: write wins, read dropped
        w_en = 1'b1;
        r_en = 1'b1;
        step();
        check("simul_write", VWrite);
        w_en = 1'b0;
        r_en = 1'b0;
        step();
        check("simul_pre", VPre);
        step();
        check("simul_no_sense", VPre);

        // Reset during SENSE1
        r_en = 1'b1;
        step();
        check("rstmid_sense1", VSense1);
        r_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_async", VPre);
        step();
        check("rstmid_held", VPre);
        rst = 1'b0;
        step();
        check("rstmid_no_sense2", VPre);

        // First request after reset release is accepted
        w_en = 1'b1;
        step();
        check("post_rst_write", VWrite);
        w_en = 1'b0;
        step();
        check("post_rst_pre", VPre);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
